// File: rtl/strela_pkg.sv
// Shared constants and types for the STRELA functional-unit operand path.
package strela_pkg;

  localparam int EB_DEPTH = 2;
  localparam logic [1:0] EB_FULL = 2'(EB_DEPTH);

  typedef struct packed {
    logic use_1;
    logic use_2;
    logic use_c;
    logic init_valid;
  } fu_join_cfg_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } join_state_t;

endpackage

// File: rtl/fu_elastic_buffer.sv
// Two-entry elastic FIFO for one FU operand channel; the head entry is always driven on dout.
module fu_elastic_buffer
  import strela_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [EB_DEPTH];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic [1:0]       count_next;

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + 2'd1;
    end else if (pop && !push) begin
      count_next = count_reg - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else if (clr) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  // Storage is not wiped by clr: the count alone decides what is live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < EB_DEPTH; i++) mem[i] <= '0;
    end else if (push && !clr) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/fu_operand_join.sv
// Operand join in front of the CGRA data FU: buffers din_1/din_2/cin, joins the required
// channels, strobes the FU and tracks validity of the FU result register (incl. initial data).
module fu_operand_join
  import strela_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  cfg_use_1,
  input  logic                  cfg_use_2,
  input  logic                  cfg_use_c,
  input  logic                  cfg_init_valid,
  input  logic [DATA_WIDTH-1:0] in1_data,
  input  logic                  in1_valid,
  output logic                  in1_ready,
  input  logic [DATA_WIDTH-1:0] in2_data,
  input  logic                  in2_valid,
  output logic                  in2_ready,
  input  logic                  inc_data,
  input  logic                  inc_valid,
  output logic                  inc_ready,
  output logic [DATA_WIDTH-1:0] fu_din_1,
  output logic [DATA_WIDTH-1:0] fu_din_2,
  output logic                  fu_cin,
  output logic                  fu_enable,
  output logic                  out_valid,
  input  logic                  out_ready
);

  fu_join_cfg_t cfg;
  join_state_t  state_reg, state_next;
  logic         out_valid_reg, out_valid_next;

  logic [1:0]            cnt_1, cnt_2, cnt_c;
  logic [DATA_WIDTH-1:0] head_1, head_2;
  logic                  head_c;
  logic                  init_done, head_ok, can_accept, fire;

  assign cfg = '{use_1: cfg_use_1, use_2: cfg_use_2, use_c: cfg_use_c,
                 init_valid: cfg_init_valid};

  assign init_done = (state_reg == RUN);

  // Ready is held low during the init cycle so nothing queues before the FU has loaded.
  assign in1_ready = cfg.use_1 && init_done && (cnt_1 != EB_FULL);
  assign in2_ready = cfg.use_2 && init_done && (cnt_2 != EB_FULL);
  assign inc_ready = cfg.use_c && init_done && (cnt_c != EB_FULL);

  assign head_ok    = (!cfg.use_1 || (cnt_1 != 2'd0)) &&
                      (!cfg.use_2 || (cnt_2 != 2'd0)) &&
                      (!cfg.use_c || (cnt_c != 2'd0));
  assign can_accept = !out_valid_reg || out_ready;
  assign fire       = head_ok && can_accept && init_done;

  fu_elastic_buffer #(.WIDTH(DATA_WIDTH)) u_eb_1 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (in1_valid && in1_ready),
    .pop   (fire && cfg.use_1),
    .din   (in1_data),
    .dout  (head_1),
    .count (cnt_1)
  );

  fu_elastic_buffer #(.WIDTH(DATA_WIDTH)) u_eb_2 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (in2_valid && in2_ready),
    .pop   (fire && cfg.use_2),
    .din   (in2_data),
    .dout  (head_2),
    .count (cnt_2)
  );

  fu_elastic_buffer #(.WIDTH(1)) u_eb_c (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (inc_valid && inc_ready),
    .pop   (fire && cfg.use_c),
    .din   (inc_data),
    .dout  (head_c),
    .count (cnt_c)
  );

  assign fu_din_1  = cfg.use_1 ? head_1 : '0;
  assign fu_din_2  = cfg.use_2 ? head_2 : '0;
  assign fu_cin    = cfg.use_c ? head_c : 1'b0;
  assign fu_enable = fire;
  assign out_valid = out_valid_reg;

  always_comb begin
    state_next     = state_reg;
    out_valid_next = out_valid_reg;
    if (clr) begin
      state_next     = INIT;
      out_valid_next = 1'b0;
    end else if (state_reg == INIT) begin
      // The FU loads initial_data this cycle; it only counts as a token when configured so.
      state_next     = RUN;
      out_valid_next = cfg.init_valid;
    end else if (fire) begin
      out_valid_next = 1'b1;
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= INIT;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= out_valid_next;
    end
  end

endmodule
